// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: pixel/line counters, blanking flag, line/frame
// pulses and polarity-configurable hsync/vsync delayed to match the pixel path.
module vga_sync_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int HSYNC_POL  = 0,
  parameter int VSYNC_POL  = 0,
  parameter int SYNC_DELAY = 1
) (
  input  logic        pixel_clk,
  input  logic        reset_n,
  output logic [15:0] pixel_col,
  output logic [15:0] pixel_row,
  output logic        data_reset,
  output logic        hsync,
  output logic        vsync,
  output logic        line_start,
  output logic        frame_start
);

  localparam logic [15:0] H_TOTAL  = 16'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK);
  localparam logic [15:0] V_TOTAL  = 16'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK);
  localparam logic [15:0] H_VIS    = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS    = 16'(V_VISIBLE);
  localparam logic [15:0] HS_START = 16'(H_VISIBLE + H_FRONT);
  localparam logic [15:0] HS_END   = 16'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [15:0] VS_START = 16'(V_VISIBLE + V_FRONT);
  localparam logic [15:0] VS_END   = 16'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic        HS_ACT   = (HSYNC_POL != 0);
  localparam logic        VS_ACT   = (VSYNC_POL != 0);

  function automatic logic in_window(input logic [15:0] cnt,
                                     input logic [15:0] lo,
                                     input logic [15:0] hi);
    return (cnt >= lo) && (cnt < hi);
  endfunction

  function automatic logic sync_level(input logic active, input logic act_lvl);
    return active ? act_lvl : ~act_lvl;
  endfunction

  logic [15:0] h_cnt;
  logic [15:0] v_cnt;
  logic [15:0] h_nxt;
  logic [15:0] v_nxt;
  logic        hs_raw_p0;
  logic        vs_raw_p0;
  logic [SYNC_DELAY-1:0] hs_dly_p1;
  logic [SYNC_DELAY-1:0] vs_dly_p1;

  always_comb begin
    h_nxt = h_cnt + 16'd1;
    v_nxt = v_cnt;
    if (h_cnt == H_TOTAL - 16'd1) begin
      h_nxt = '0;
      if (v_cnt == V_TOTAL - 16'd1) v_nxt = '0;
      else                          v_nxt = v_cnt + 16'd1;
    end
  end

  // p0: counters plus flags registered from the next-state counts so they
  // line up with pixel_col/pixel_row in the same cycle
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      data_reset  <= 1'b1;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      h_cnt       <= h_nxt;
      v_cnt       <= v_nxt;
      data_reset  <= !((h_nxt < H_VIS) && (v_nxt < V_VIS));
      line_start  <= (h_nxt == 16'd0);
      frame_start <= (h_nxt == 16'd0) && (v_nxt == 16'd0);
    end
  end

  assign pixel_col = h_cnt;
  assign pixel_row = v_cnt;

  assign hs_raw_p0 = in_window(h_cnt, HS_START, HS_END);
  assign vs_raw_p0 = in_window(v_cnt, VS_START, VS_END);

  // p1: sync shift chain; reset loads the idle level so a pulse in flight is dropped
  always_ff @(posedge pixel_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_dly_p1 <= {SYNC_DELAY{~HS_ACT}};
      vs_dly_p1 <= {SYNC_DELAY{~VS_ACT}};
    end else begin
      hs_dly_p1[0] <= sync_level(hs_raw_p0, HS_ACT);
      vs_dly_p1[0] <= sync_level(vs_raw_p0, VS_ACT);
      for (int i = 1; i < SYNC_DELAY; i++) begin
        hs_dly_p1[i] <= hs_dly_p1[i-1];
        vs_dly_p1[i] <= vs_dly_p1[i-1];
      end
    end
  end

  assign hsync = hs_dly_p1[SYNC_DELAY-1];
  assign vsync = vs_dly_p1[SYNC_DELAY-1];

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default timing with delays 1 and 3, plus a reduced-size raster
// (24x13, delay 2) for frame, vsync and mid-frame reset behaviour.
module tb_vga_sync_gen;

  logic pixel_clk = 1'b0;
  logic reset_n   = 1'b0;
  always #5 pixel_clk = ~pixel_clk;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  logic [15:0] d_col, d_row, t_col, t_row, s_col, s_row;
  logic d_dr, d_hs, d_vs, d_ls, d_fs;
  logic t_dr, t_hs, t_vs, t_ls, t_fs;
  logic s_dr, s_hs, s_vs, s_ls, s_fs;

  vga_sync_gen #(.SYNC_DELAY(1)) u_def (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .pixel_col(d_col), .pixel_row(d_row),
    .data_reset(d_dr), .hsync(d_hs), .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs)
  );

  vga_sync_gen #(.SYNC_DELAY(3)) u_d3 (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .pixel_col(t_col), .pixel_row(t_row),
    .data_reset(t_dr), .hsync(t_hs), .vsync(t_vs), .line_start(t_ls), .frame_start(t_fs)
  );

  vga_sync_gen #(
    .H_VISIBLE(16), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
    .V_VISIBLE(8),  .V_FRONT(1), .V_SYNC(2), .V_BACK(2),
    .SYNC_DELAY(2)
  ) u_sm (
    .pixel_clk(pixel_clk), .reset_n(reset_n), .pixel_col(s_col), .pixel_row(s_row),
    .data_reset(s_dr), .hsync(s_hs), .vsync(s_vs), .line_start(s_ls), .frame_start(s_fs)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
    edges++;
  endtask

  task automatic step_to(input int n);
    while (edges < n) step();
  endtask

  int lo_d, lo_t, fs_first, fs_second, ls_cnt, vs_lo, vs_first, hs_lo, d_fs_cnt;

  initial begin
    // reset held for 10 clocks
    reset_n = 1'b0;
    repeat (10) @(posedge pixel_clk);
    #1;
    check_val("rst_col", d_col, 0);
    check_val("rst_row", d_row, 0);
    check_val("rst_dr", d_dr, 1);
    check_val("rst_hs", d_hs, 1);
    check_val("rst_vs", d_vs, 1);
    check_val("rst_ls", d_ls, 0);
    check_val("rst_fs", d_fs, 0);
    check_val("rst_d3", {t_col, t_row}, 0);
    check_val("rst_d3_flags", {t_dr, t_hs, t_vs, t_ls, t_fs}, 5'b11100);
    check_val("rst_sm_flags", {s_dr, s_hs, s_vs, s_ls, s_fs}, 5'b11100);

    @(negedge pixel_clk);
    reset_n = 1'b1;
    edges = 0;

    step_to(1);
    check_val("rel_col1", d_col, 1);
    check_val("rel_row", d_row, 0);
    check_val("rel_hs", d_hs, 1);
    check_val("rel_dr", d_dr, 0);
    check_val("rel_ls", d_ls, 0);
    check_val("rel_sm_col1", s_col, 1);
    step_to(2);
    check_val("rel_col2", d_col, 2);
    step_to(3);
    check_val("rel_col3", d_col, 3);

    step_to(639);
    check_val("col639", d_col, 639);
    check_val("dr_col639", d_dr, 0);
    step_to(640);
    check_val("dr_col640", d_dr, 1);

    lo_d = 0;
    lo_t = 0;
    while (edges < 800) begin
      step();
      if (!d_hs) lo_d++;
      if (!t_hs) lo_t++;
      if (edges == 656) check_val("hs1_656", d_hs, 1);
      if (edges == 657) check_val("hs1_657", d_hs, 0);
      if (edges == 752) check_val("hs1_752", d_hs, 0);
      if (edges == 753) check_val("hs1_753", d_hs, 1);
      if (edges == 658) check_val("hs3_658", t_hs, 1);
      if (edges == 659) check_val("hs3_659", t_hs, 0);
      if (edges == 754) check_val("hs3_754", t_hs, 0);
      if (edges == 755) check_val("hs3_755", t_hs, 1);
      if (edges == 799) begin
        check_val("col799", d_col, 799);
        check_val("dr_col799", d_dr, 1);
        check_val("ls_col799", d_ls, 0);
      end
    end
    check_val("hs1_width", lo_d, 96);
    check_val("hs3_width", lo_t, 96);
    check_val("wrap0_col", d_col, 0);
    check_val("wrap0_row", d_row, 1);
    check_val("wrap0_ls", d_ls, 1);
    check_val("wrap0_dr", d_dr, 0);
    step();
    check_val("wrap0_ls_drop", d_ls, 0);
    check_val("wrap0_col1", d_col, 1);

    step_to(8799);
    check_val("r10_col", d_col, 799);
    check_val("r10_row", d_row, 10);
    step_to(8800);
    check_val("r11_col", d_col, 0);
    check_val("r11_row", d_row, 11);
    check_val("r11_ls", d_ls, 1);
    check_val("r11_fs", d_fs, 0);
    check_val("r11_d3", {t_col, t_row}, {16'd0, 16'd11});

    // small raster sits at col 21, row 2 with hsync active
    step_to(8805);
    check_val("sm_pre_col", s_col, 21);
    check_val("sm_pre_row", s_row, 2);
    check_val("sm_pre_hs", s_hs, 0);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("mid_sm_hs", s_hs, 1);
    check_val("mid_sm_cnt", {s_col, s_row}, 0);
    check_val("mid_sm_dr", s_dr, 1);
    check_val("mid_def_cnt", {d_col, d_row}, 0);
    check_val("mid_def_ls", d_ls, 0);

    repeat (3) @(negedge pixel_clk);
    reset_n = 1'b1;
    edges = 0;

    fs_first = -1;
    fs_second = -1;
    vs_first = -1;
    ls_cnt = 0;
    vs_lo = 0;
    hs_lo = 0;
    d_fs_cnt = 0;
    while (edges < 700) begin
      step();
      if (s_fs) begin
        if (fs_first < 0) fs_first = edges;
        else if (fs_second < 0) fs_second = edges;
      end
      if (edges <= 312) begin
        if (s_ls) ls_cnt++;
        if (!s_vs) begin
          vs_lo++;
          if (vs_first < 0) vs_first = edges;
        end
      end
      if (edges < 24 && !s_hs) hs_lo++;
      if (d_fs) d_fs_cnt++;
      if (edges == 168) check_val("sm_dr_r7c0", s_dr, 0);
      if (edges == 183) check_val("sm_dr_r7c15", s_dr, 0);
      if (edges == 184) check_val("sm_dr_r7c16", s_dr, 1);
      if (edges == 192) check_val("sm_dr_r8c0", s_dr, 1);
      if (edges == 207) check_val("sm_dr_r8c15", s_dr, 1);
    end
    check_val("sm_fs_first", fs_first, 312);
    check_val("sm_fs_period", fs_second - fs_first, 312);
    check_val("sm_ls_per_frame", ls_cnt, 13);
    check_val("sm_vs_width", vs_lo, 48);
    check_val("sm_vs_start", vs_first, 218);
    check_val("sm_hs_width", hs_lo, 3);
    check_val("def_no_fs", d_fs_cnt, 0);
    check_val("def_restart", {d_col, d_row}, {16'd700, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
Name: vga_sync_gen

Overview:
- Generates VGA raster timing for the 80x25 text display path.
- Drives pixel_col, pixel_row and data_reset into the VGA pixel generator, and drives the hsync/vsync pins.
- Sync outputs are delayed so they stay aligned with the pixel generator's one-cycle registered colour output.
- Defaults give 640x480 @ 60 Hz from a 25.175 MHz pixel_clk.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch (clocks)
- H_SYNC, 96, hsync pulse width (clocks)
- H_BACK, 48, horizontal back porch (clocks)
- V_VISIBLE, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BACK, 33, vertical back porch (lines)
- HSYNC_POL, 0, hsync active level (0 = active-low)
- VSYNC_POL, 0, vsync active level (0 = active-low)
- SYNC_DELAY, 1, pipeline depth for hsync/vsync, legal range 1..4

Ports:
- pixel_clk  in  1  pixel clock; all logic on its rising edge
- reset_n  in  1  reset, asynchronous, active-low
- pixel_col  out  16  current horizontal count, 0..H_TOTAL-1
- pixel_row  out  16  current vertical count, 0..V_TOTAL-1
- data_reset  out  1  high when outside the visible area (blanking)
- hsync  out  1  horizontal sync to pin
- vsync  out  1  vertical sync to pin
- line_start  out  1  one-cycle pulse when pixel_col == 0
- frame_start  out  1  one-cycle pulse when pixel_col == 0 and pixel_row == 0

Behaviour:
- Derived constants:
  - H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK (default 800)
  - V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK (default 525)
- Counters: h_cnt and v_cnt are 16-bit registers; pixel_col = h_cnt and pixel_row = v_cnt directly, with no output logic.
  - Every edge: h_cnt increments.
  - If h_cnt == H_TOTAL-1: h_cnt -> 0 and v_cnt increments.
  - If also v_cnt == V_TOTAL-1: v_cnt -> 0.
  - Counts never exceed TOTAL-1; upper bits stay zero.
- data_reset: registered from next-state counters, so it is valid in the same cycle as pixel_col/pixel_row. Equals NOT(h_cnt < H_VISIBLE AND v_cnt < V_VISIBLE).
- line_start and frame_start: registered the same way, aligned with the counters (not delayed).
- Sync decode:
  - hs_raw active when H_VISIBLE+H_FRONT <= h_cnt < H_VISIBLE+H_FRONT+H_SYNC (default 656..751).
  - vs_raw active when V_VISIBLE+V_FRONT <= v_cnt < V_VISIBLE+V_FRONT+V_SYNC (default 490..491), for the whole line including blanking.
  - Active level set by HSYNC_POL / VSYNC_POL.
- Sync delay: hsync/vsync pass through a SYNC_DELAY-stage register shift chain.
  - hsync at cycle t reflects the counters at cycle t-SYNC_DELAY.
  - No combinational path from counters to pins.
- Reset (async, reset_n low):
  - h_cnt = v_cnt = 0, data_reset = 1, line_start = frame_start = 0.
  - All sync shift stages load the inactive level, so hsync = vsync = 1 with default polarity.
- Reset release: the first rising edge after reset_n goes high moves h_cnt to 1. line_start/frame_start do not pulse for the reset-held (0,0) state; the first frame_start is at the next wrap.
- Reset mid-frame: counters clear immediately, sync pins go inactive immediately (asynchronous), and no partial sync pulse is extended.
- Frame period: H_TOTAL * V_TOTAL clocks (420000 default), with exactly one frame_start per frame and V_TOTAL line_start pulses per frame.

Test Plan:
- Reset: hold reset_n low 10 clocks -> pixel_col = 0, pixel_row = 0, data_reset = 1, hsync = vsync = 1, line_start = frame_start = 0. Release -> pixel_col counts 1, 2, 3…
- Visible boundary: row 0 -> data_reset = 0 at col 0..639; data_reset = 1 at col 640..799. At col 639, row 479 -> data_reset = 0; row 480 -> data_reset = 1 for the whole line.
- Hsync with SYNC_DELAY = 1: hsync falls the cycle after pixel_col = 656 and rises the cycle after pixel_col = 752, giving exactly 96 clocks low. Repeat with SYNC_DELAY = 3 -> edges shift by 2 more cycles.
- Line/frame wrap: pixel_col = 799, row 10 -> next cycle col 0, row 11, line_start = 1 for one cycle. Col 799, row 524 -> col 0, row 0, frame_start = 1 for one cycle. frame_start to frame_start = 420000 clocks.
- Vsync: low for exactly 1600 clocks (rows 490..491), starting SYNC_DELAY cycles after (col 0, row 490).
- Mid-frame reset: assert reset_n low during hsync-active at col 700, row 300 -> hsync = 1 and counters = 0 without waiting for a clock. After release, the timing restarts cleanly and the first frame_start arrives at clock 420000.
